// File: rtl/gray_updown_count.sv
// Up/down counter whose only state is an N-bit Gray register; binary view is decoded combinationally.
// Optional saturation at the ends and a sticky flag that records every end crossing or saturation.
module gray_updown_count #(
    parameter int             N        = 8,
    parameter int             SATURATE = 0,
    parameter logic [N-1:0]   INIT     = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_bin,
    input  logic         clear_flag,
    output logic [N-1:0] gray_count,
    output logic [N-1:0] bin_count,
    output logic         at_limit,
    output logic         limit_hit
);

    localparam logic [N-1:0] INIT_GRAY = INIT ^ (INIT >> 1);
    localparam logic [N-1:0] ALL_ONES  = '1;
    localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] r_gray;
    logic         r_limit_hit;
    logic [N-1:0] w_bin;
    logic [N-1:0] w_bin_step;
    logic [N-1:0] w_gray_step;
    logic [N-1:0] w_gray_load;
    logic         w_at_limit;
    logic         w_hold;

    // Binary bit i is the XOR of all Gray bits from i upward.
    for (genvar i = 0; i < N; i++) begin : g_decode
        assign w_bin[i] = ^r_gray[N-1:i];
    end

    assign w_at_limit  = up ? (w_bin == ALL_ONES) : (w_bin == '0);
    assign w_bin_step  = up ? (w_bin + ONE) : (w_bin - ONE);
    assign w_gray_step = w_bin_step ^ (w_bin_step >> 1);
    assign w_gray_load = load_bin ^ (load_bin >> 1);
    assign w_hold      = (SATURATE != 0) && w_at_limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gray      <= INIT_GRAY;
            r_limit_hit <= 1'b0;
        end else begin
            if (load) begin
                r_gray <= w_gray_load;
            end else if (enable && !w_hold) begin
                r_gray <= w_gray_step;
            end
            // A crossing in the same cycle as a clear keeps the flag set.
            if (!load && enable && w_at_limit) begin
                r_limit_hit <= 1'b1;
            end else if (clear_flag) begin
                r_limit_hit <= 1'b0;
            end
        end
    end

    assign gray_count = r_gray;
    assign bin_count  = w_bin;
    assign at_limit   = w_at_limit;
    assign limit_hit  = r_limit_hit;

endmodule

// File: tb/tb_gray_updown_count.sv
// Bench for gray_updown_count (N=4): wrapping, saturating and INIT=3 instances share stimulus,
// each tracked by an arithmetic reference model of the counter value and sticky flag.
module tb_gray_updown_count;

    logic       clk;
    logic       rst_as;
    logic       rst_i;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] lbin;
    logic       clr;

    logic [3:0] gray_o [3];
    logic [3:0] bin_o  [3];
    logic       atl_o  [3];
    logic       hit_o  [3];

    int   m_bin [3];
    logic m_hit [3];
    int   sat_k [3] = '{0, 1, 0};

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [3:0] exp_g [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    int exp_down [6] = '{4, 3, 2, 1, 0, 15};

    gray_updown_count #(.N(4), .SATURATE(0), .INIT(4'd0)) u_wrap (
        .clk(clk), .reset(rst_as), .enable(en), .up(up), .load(ld), .load_bin(lbin),
        .clear_flag(clr), .gray_count(gray_o[0]), .bin_count(bin_o[0]),
        .at_limit(atl_o[0]), .limit_hit(hit_o[0]));

    gray_updown_count #(.N(4), .SATURATE(1), .INIT(4'd0)) u_sat (
        .clk(clk), .reset(rst_as), .enable(en), .up(up), .load(ld), .load_bin(lbin),
        .clear_flag(clr), .gray_count(gray_o[1]), .bin_count(bin_o[1]),
        .at_limit(atl_o[1]), .limit_hit(hit_o[1]));

    gray_updown_count #(.N(4), .SATURATE(0), .INIT(4'd3)) u_init (
        .clk(clk), .reset(rst_i), .enable(en), .up(up), .load(ld), .load_bin(lbin),
        .clear_flag(clr), .gray_count(gray_o[2]), .bin_count(bin_o[2]),
        .at_limit(atl_o[2]), .limit_hit(hit_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] to_gray(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("gray%0d", k), 32'(gray_o[k]), 32'(to_gray(m_bin[k])));
            check($sformatf("bin%0d", k), 32'(bin_o[k]), 32'(m_bin[k]));
            check($sformatf("at_limit%0d", k), 32'(atl_o[k]),
                  32'(up ? (m_bin[k] == 15) : (m_bin[k] == 0)));
            check($sformatf("limit_hit%0d", k), 32'(hit_o[k]), 32'(m_hit[k]));
        end
    endtask

    // One clock with the given inputs; models advance unless their instance is in reset.
    task automatic cycle(input logic e, input logic u, input logic l,
                         input logic [3:0] b, input logic c);
        int   nb   [3];
        logic nh   [3];
        logic step [3];
        logic lim;
        en = e; up = u; ld = l; lbin = b; clr = c;
        for (int k = 0; k < 3; k++) begin
            nb[k] = m_bin[k];
            nh[k] = m_hit[k];
            step[k] = 1'b0;
            if (!((k < 2 && rst_as) || (k == 2 && rst_i))) begin
                lim = u ? (m_bin[k] == 15) : (m_bin[k] == 0);
                if (l) begin
                    nb[k] = int'(b);
                end else if (e && !(lim && sat_k[k] != 0)) begin
                    nb[k] = (m_bin[k] + (u ? 1 : 15)) % 16;
                    step[k] = 1'b1;
                end
                if (!l && e && lim) nh[k] = 1'b1;
                else if (c) nh[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (step[k])
                check($sformatf("onebit%0d", k),
                      32'($countones(gray_o[k] ^ to_gray(m_bin[k]))), 32'd1);
            m_bin[k] = nb[k];
            m_hit[k] = nh[k];
        end
        check_all();
    endtask

    initial begin
        rst_as = 1'b1; rst_i = 1'b1;
        en = 1'b0; up = 1'b1; ld = 1'b0; lbin = 4'd0; clr = 1'b0;
        m_bin = '{0, 0, 3};
        m_hit = '{1'b0, 1'b0, 1'b0};
        #12;
        check("reset_gray_wrap", 32'(gray_o[0]), 32'h0);
        check("reset_gray_init", 32'(gray_o[2]), 32'b0010);
        check_all();
        rst_as = 1'b0; rst_i = 1'b0;

        // Full up sweep with wrap
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
            check($sformatf("sweep_gray_%0d", i + 1), 32'(gray_o[0]), 32'(exp_g[i + 1]));
            if (i < 15) check("sweep_no_hit", 32'(hit_o[0]), 32'd0);
        end
        check("sweep_hit_after_wrap", 32'(hit_o[0]), 32'd1);

        // Load 5 then count down across zero
        cycle(1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        check("load5_gray", 32'(gray_o[0]), 32'b0111);
        check("load5_bin", 32'(bin_o[0]), 32'd5);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
            check($sformatf("down_bin_%0d", i), 32'(bin_o[0]), 32'(exp_down[i]));
            if (exp_down[i] == 0) check("down_at_limit_zero", 32'(atl_o[0]), 32'd1);
        end
        check("down_end_gray", 32'(gray_o[0]), 32'b1000);

        // Load beats enable
        cycle(1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
        check("load_priority_gray", 32'(gray_o[0]), 32'b1101);

        // Clear racing a wrap step: set wins
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        check("clear_alone", 32'(hit_o[0]), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        check("set_beats_clear", 32'(hit_o[0]), 32'd1);
        check("wrap_to_zero", 32'(gray_o[0]), 32'd0);

        // Saturating hold at the top
        cycle(1'b0, 1'b1, 1'b1, 4'd15, 1'b1);
        check("sat_hit_cleared", 32'(hit_o[1]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
            check($sformatf("sat_hold_%0d", i), 32'(gray_o[1]), 32'b1000);
        end
        check("sat_hit", 32'(hit_o[1]), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        check("sat_clear", 32'(hit_o[1]), 32'd0);

        // Asynchronous reset mid-cycle on the INIT=3 instance
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        #3;
        rst_i = 1'b1;
        #1;
        check("async_rst_gray", 32'(gray_o[2]), 32'b0010);
        check("async_rst_hit", 32'(hit_o[2]), 32'd0);
        m_bin[2] = 3;
        m_hit[2] = 1'b0;
        cycle(1'b1, 1'b1, 1'b1, 4'd12, 1'b0);
        rst_i = 1'b0;
        #1;
        check("resume_3", 32'(bin_o[2]), 32'd3);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        check("resume_4", 32'(bin_o[2]), 32'd4);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        check("resume_5", 32'(bin_o[2]), 32'd5);

        // Random traffic, loads biased toward the ends
        for (int i = 0; i < 400; i++) begin
            logic [3:0] rb;
            case ($urandom_range(3))
                0: rb = 4'd0;
                1: rb = 4'd15;
                default: rb = 4'($urandom_range(15));
            endcase
            cycle(1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                  1'($urandom_range(7) == 0), rb, 1'($urandom_range(5) == 0));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
